// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter in front of one single-port RAM (req/gnt/rvalid).
// In-order responses are routed back through a small tag FIFO; out-of-range data accesses are answered locally.
module mem_port_arbiter #(
    parameter int unsigned            ADDR_WIDTH      = 32,
    parameter int unsigned            DATA_WIDTH      = 32,
    parameter int unsigned            MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0]  MEM_BASE        = '0,
    parameter int unsigned            MEM_SIZE        = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      m0_req_i,
    output logic                      m0_gnt_o,
    output logic                      m0_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]     m0_addr_i,
    output logic [DATA_WIDTH-1:0]     m0_rdata_o,

    input  logic                      m1_req_i,
    output logic                      m1_gnt_o,
    output logic                      m1_rvalid_o,
    input  logic                      m1_we_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_be_i,
    input  logic [ADDR_WIDTH-1:0]     m1_addr_i,
    input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
    output logic [DATA_WIDTH-1:0]     m1_rdata_o,
    output logic                      m1_err_o,

    output logic                      s_req_o,
    input  logic                      s_gnt_i,
    input  logic                      s_rvalid_i,
    output logic                      s_we_o,
    output logic [DATA_WIDTH/8-1:0]   s_be_o,
    output logic [ADDR_WIDTH-1:0]     s_addr_o,
    output logic [DATA_WIDTH-1:0]     s_wdata_o,
    input  logic [DATA_WIDTH-1:0]     s_rdata_i
);

    localparam int unsigned BeWidth  = DATA_WIDTH / 8;
    localparam int unsigned PtrWidth = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned LimWidth = ADDR_WIDTH + 1;

    // Window bounds carry one extra bit so MEM_BASE+MEM_SIZE cannot wrap.
    localparam logic [LimWidth-1:0] MemLo    = LimWidth'(MEM_BASE);
    localparam logic [LimWidth-1:0] MemHi    = MemLo + LimWidth'(MEM_SIZE);
    localparam logic [PtrWidth-1:0] PtrLast  = PtrWidth'(MAX_OUTSTANDING - 1);
    localparam logic [CntWidth-1:0] CntFull  = CntWidth'(MAX_OUTSTANDING);

    logic [MAX_OUTSTANDING-1:0] tag_q;
    logic [PtrWidth-1:0]        wr_ptr_q;
    logic [PtrWidth-1:0]        rd_ptr_q;
    logic [CntWidth-1:0]        count_q;
    logic                       last_grant_q;
    logic                       err_pending_q;

    logic fifo_full;
    logic fifo_empty;
    logic m1_oor;
    logic sel_m1;
    logic any_req;
    logic err_take;
    logic fwd;
    logic push;
    logic pop;
    logic rsp_tag;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrWidth'(1);
    endfunction

    // Selection, range check and handshake qualification
    always_comb begin
        fifo_full  = 1'b0;
        fifo_empty = 1'b0;
        m1_oor     = 1'b0;
        sel_m1     = 1'b0;
        any_req    = 1'b0;
        err_take   = 1'b0;
        fwd        = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        rsp_tag    = 1'b0;

        fifo_full  = (count_q == CntFull);
        fifo_empty = (count_q == '0);
        m1_oor     = ({1'b0, m1_addr_i} < MemLo) || ({1'b0, m1_addr_i} >= MemHi);
        // Master 1 wins a conflict only when master 0 was granted last.
        sel_m1     = m1_req_i && (!m0_req_i || !last_grant_q);
        any_req    = m0_req_i || m1_req_i;
        // A local error must not overtake RAM responses still in flight.
        err_take   = rst_ni && sel_m1 && m1_oor && fifo_empty && !err_pending_q;
        fwd        = rst_ni && any_req && !fifo_full && !(sel_m1 && m1_oor);
        push       = fwd && s_gnt_i;
        pop        = rst_ni && s_rvalid_i && !fifo_empty;
        rsp_tag    = tag_q[rd_ptr_q];
    end

    // Request mux towards the RAM and grant/response fan-out to the masters
    always_comb begin
        s_req_o     = 1'b0;
        s_we_o      = 1'b0;
        s_be_o      = {BeWidth{1'b1}};
        s_addr_o    = m0_addr_i;
        s_wdata_o   = '0;
        m0_gnt_o    = 1'b0;
        m1_gnt_o    = 1'b0;
        m0_rvalid_o = 1'b0;
        m1_rvalid_o = 1'b0;
        m1_err_o    = 1'b0;
        m0_rdata_o  = s_rdata_i;
        m1_rdata_o  = s_rdata_i;

        s_req_o = fwd;
        if (sel_m1) begin
            s_we_o    = m1_we_i;
            s_be_o    = m1_be_i;
            s_addr_o  = m1_addr_i;
            s_wdata_o = m1_wdata_i;
        end

        m0_gnt_o = push && !sel_m1;
        m1_gnt_o = (push && sel_m1) || err_take;

        m0_rvalid_o = pop && !rsp_tag;
        m1_rvalid_o = (pop && rsp_tag) || (rst_ni && err_pending_q);
        m1_err_o    = rst_ni && err_pending_q;
        if (err_pending_q) begin
            m1_rdata_o = '0;
        end
    end

    // Tag FIFO, round-robin pointer and pending local error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            last_grant_q  <= 1'b1;
            err_pending_q <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= sel_m1;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CntWidth'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntWidth'(1);
            end
            if (push) begin
                last_grant_q <= sel_m1;
            end else if (err_take) begin
                last_grant_q <= 1'b1;
            end
            err_pending_q <= err_take;
        end
    end

    // A RAM response with nothing outstanding is dropped; flag it in simulation.
    rsp_without_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                      !(s_rvalid_i && fifo_empty));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: request/RAM-slave drivers, a transaction-level model
// of arbitration and memory contents, and a response scoreboard drained by a separate monitor.
module tb_mem_port_arbiter;

    localparam int unsigned MAXO = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        m0_req_i = 1'b0, m0_gnt_o, m0_rvalid_o;
    logic [31:0] m0_addr_i = '0, m0_rdata_o;
    logic        m1_req_i = 1'b0, m1_gnt_o, m1_rvalid_o, m1_we_i = 1'b0, m1_err_o;
    logic [3:0]  m1_be_i = '0;
    logic [31:0] m1_addr_i = '0, m1_wdata_i = '0, m1_rdata_o;
    logic        s_req_o, s_gnt_i = 1'b0, s_rvalid_i = 1'b0, s_we_o;
    logic [3:0]  s_be_o;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i = '0;

    mem_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAXO),
        .MEM_BASE(32'h0000_0000), .MEM_SIZE(1024)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_addr_i(m0_addr_i), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_we_o(s_we_o),
        .s_be_o(s_be_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } m1req_t;
    typedef struct { logic err; logic chk_data; logic [31:0] data; } sb_t;
    typedef struct { logic [31:0] data; int ready; } ramrsp_t;

    // Pending master requests, scoreboard and RAM-slave state
    logic [31:0] m0_list[$];
    m1req_t      m1_list[$];
    sb_t         sb0[$], sb1[$];
    ramrsp_t     ram_q[$];
    logic [31:0] ram_mem [256];
    logic [31:0] ref_mem [256];
    logic        owners[$];
    logic        last_m = 1'b1;
    logic        errp   = 1'b0;
    int          cyc = 0, last_ready = 0;
    int          gnt_pct = 100, lat_min = 0, lat_max = 0;
    int          total = 0, bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic bit out_of_range(input logic [31:0] a);
        return ({32'h0, a} < 64'h0) || ({32'h0, a} >= 64'd1024);
    endfunction

    // One clock: drive at negedge, check and advance the model 2 time units later
    task automatic step();
        bit          ram_fire, full, sel1, oor, e_sreq, e_hs, e_err, e_m0g, e_m1g;
        bit          e_m0rv, e_m1rv;
        logic [31:0] rd;
        int          rdy;
        m1req_t      h1;
        @(negedge clk_i);
        rst_ni   = 1'b1;
        m0_req_i = (m0_list.size() > 0);
        m0_addr_i = m0_req_i ? m0_list[0] : $urandom;
        m1_req_i = (m1_list.size() > 0);
        if (m1_req_i) h1 = m1_list[0];
        else h1 = '{we: 1'($urandom), be: 4'($urandom), addr: $urandom, wdata: $urandom};
        m1_we_i = h1.we; m1_be_i = h1.be; m1_addr_i = h1.addr; m1_wdata_i = h1.wdata;
        s_gnt_i  = ($urandom_range(0, 99) < gnt_pct);
        ram_fire = (ram_q.size() > 0) && (ram_q[0].ready <= cyc);
        s_rvalid_i = ram_fire;
        s_rdata_i  = ram_fire ? ram_q[0].data : $urandom;
        #2;
        full  = (owners.size() >= MAXO);
        sel1  = m1_req_i && (!m0_req_i || last_m == 1'b0);
        oor   = out_of_range(m1_addr_i);
        e_err = 1'b0; e_sreq = 1'b0;
        if (sel1 && oor) e_err = (owners.size() == 0) && !errp;
        else if (m0_req_i || m1_req_i) e_sreq = !full;
        e_hs  = e_sreq && s_gnt_i;
        e_m0g = e_hs && !sel1;
        e_m1g = (e_hs && sel1) || e_err;
        e_m0rv = ram_fire && owners.size() > 0 && owners[0] == 1'b0;
        e_m1rv = (ram_fire && owners.size() > 0 && owners[0] == 1'b1) || errp;
        chk("m0_gnt", m0_gnt_o, e_m0g);
        chk("m1_gnt", m1_gnt_o, e_m1g);
        chk("s_req", s_req_o, e_sreq);
        chk("m0_rvalid", m0_rvalid_o, e_m0rv);
        chk("m1_rvalid", m1_rvalid_o, e_m1rv);
        chk("m1_err", m1_err_o, errp);
        if (e_sreq) begin
            chk("s_addr", s_addr_o, sel1 ? m1_addr_i : m0_addr_i);
            chk("s_we", s_we_o, sel1 && m1_we_i);
            chk("s_be", s_be_o, sel1 ? m1_be_i : 4'hF);
            if (sel1 && m1_we_i) chk("s_wdata", s_wdata_o, m1_wdata_i);
        end
        // RAM slave reacts to what the DUT actually presented
        if (s_req_o && s_gnt_i) begin
            rd = ram_mem[s_addr_o[9:2]];
            if (s_we_o) ram_mem[s_addr_o[9:2]] = merge(rd, s_wdata_o, s_be_o);
            rdy = cyc + 1 + $urandom_range(lat_min, lat_max);
            if (rdy < last_ready) rdy = last_ready;
            last_ready = rdy;
            ram_q.push_back('{data: s_we_o ? 32'h0 : rd, ready: rdy});
        end
        if (ram_fire) void'(ram_q.pop_front());
        // Reference model commit
        if (ram_fire && owners.size() > 0) void'(owners.pop_front());
        if (e_hs) begin
            owners.push_back(sel1);
            last_m = sel1;
            if (!sel1) begin
                sb0.push_back('{err: 1'b0, chk_data: 1'b1, data: ref_mem[m0_addr_i[9:2]]});
                void'(m0_list.pop_front());
            end else begin
                sb1.push_back('{err: 1'b0, chk_data: !m1_we_i, data: ref_mem[m1_addr_i[9:2]]});
                if (m1_we_i)
                    ref_mem[m1_addr_i[9:2]] = merge(ref_mem[m1_addr_i[9:2]], m1_wdata_i, m1_be_i);
                void'(m1_list.pop_front());
            end
        end
        if (e_err) begin
            last_m = 1'b1;
            sb1.push_back('{err: 1'b1, chk_data: 1'b1, data: 32'h0});
            void'(m1_list.pop_front());
        end
        errp = e_err;
        cyc++;
    endtask

    task automatic reset_phase(input int n, input bit stale);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            rst_ni = 1'b0;
            m0_req_i = 1'b1; m0_addr_i = 32'h40;
            m1_req_i = 1'b1; m1_addr_i = 32'h44; m1_we_i = 1'b0;
            s_gnt_i = 1'b1; s_rvalid_i = stale;
            #2;
            chk("rst_m0_gnt", m0_gnt_o, 0);
            chk("rst_m1_gnt", m1_gnt_o, 0);
            chk("rst_m0_rvalid", m0_rvalid_o, 0);
            chk("rst_m1_rvalid", m1_rvalid_o, 0);
            chk("rst_m1_err", m1_err_o, 0);
            chk("rst_s_req", s_req_o, 0);
            cyc++;
        end
        owners.delete(); ram_q.delete(); sb0.delete(); sb1.delete();
        errp = 1'b0; last_m = 1'b1; last_ready = cyc;
    endtask

    // Monitor: pops the scoreboard whenever a master sees a response
    initial begin
        sb_t e;
        forever begin
            @(negedge clk_i);
            #4;
            if (rst_ni && m0_rvalid_o) begin
                chk("m0_rsp_expected", 64'(sb0.size() > 0), 1);
                if (sb0.size() > 0) begin
                    e = sb0.pop_front();
                    chk("m0_rdata", m0_rdata_o, e.data);
                end
            end
            if (rst_ni && m1_rvalid_o) begin
                chk("m1_rsp_expected", 64'(sb1.size() > 0), 1);
                if (sb1.size() > 0) begin
                    e = sb1.pop_front();
                    chk("m1_rsp_err", m1_err_o, e.err);
                    if (e.chk_data) chk("m1_rdata", m1_rdata_o, e.data);
                end
            end
        end
    end

    initial begin
        int g;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = $urandom;
            ref_mem[i] = ram_mem[i];
        end
        reset_phase(3, 1'b0);

        // Master 0 streaming, 1-cycle RAM
        m0_list = '{32'h0, 32'h4, 32'h8};
        for (int i = 0; i < 6; i++) step();

        // Both masters requesting continuously
        for (int i = 0; i < 4; i++) begin
            m0_list.push_back(32'h100 + 32'(i * 4));
            m1_list.push_back('{we: 1'b0, be: 4'hF, addr: 32'h200 + 32'(i * 4), wdata: 32'h0});
        end
        for (int i = 0; i < 12; i++) step();

        // Partial write then read-back
        m1_list.push_back('{we: 1'b1, be: 4'b0011, addr: 32'h10, wdata: 32'hDEAD_BEEF});
        m1_list.push_back('{we: 1'b0, be: 4'hF, addr: 32'h10, wdata: 32'h0});
        for (int i = 0; i < 5; i++) step();

        // Out-of-range read, alone and behind an outstanding master 0 read
        m1_list.push_back('{we: 1'b0, be: 4'hF, addr: 32'h400, wdata: 32'h0});
        for (int i = 0; i < 4; i++) step();
        lat_min = 3; lat_max = 3;
        m0_list.push_back(32'h20);
        step();
        m1_list.push_back('{we: 1'b0, be: 4'hF, addr: 32'h400, wdata: 32'h0});
        for (int i = 0; i < 8; i++) step();

        // RAM withholds rvalid: only MAX_OUTSTANDING grants
        lat_min = 4; lat_max = 4;
        for (int i = 0; i < 4; i++) m0_list.push_back(32'h30 + 32'(i * 4));
        g = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            g += int'(m0_gnt_o);
        end
        chk("grants_while_full", g, 2);
        for (int i = 0; i < 16; i++) step();

        // Reset with two responses outstanding, stale rvalid during reset
        lat_min = 10; lat_max = 10;
        m0_list.push_back(32'h50); m0_list.push_back(32'h54);
        for (int i = 0; i < 10 && owners.size() < 2; i++) step();
        chk("outstanding_before_reset", owners.size(), 2);
        reset_phase(2, 1'b1);
        lat_min = 0; lat_max = 0;
        m0_list.delete(); m1_list.delete();
        m0_list.push_back(32'h60);
        m1_list.push_back('{we: 1'b0, be: 4'hF, addr: 32'h64, wdata: 32'h0});
        step();
        chk("first_conflict_m0", m0_gnt_o, 1);
        for (int i = 0; i < 6; i++) step();

        // Randomized traffic
        gnt_pct = 70; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 2000; i++) begin
            if (m0_list.size() == 0 && $urandom_range(0, 99) < 60)
                m0_list.push_back(32'($urandom_range(0, 511)) << 2);
            if (m1_list.size() == 0 && $urandom_range(0, 99) < 60) begin
                m1req_t r;
                r.we = 1'($urandom); r.be = 4'($urandom); r.wdata = $urandom;
                r.addr = 32'($urandom_range(0, 255)) << 2;
                case ($urandom_range(0, 19))
                    0: r.addr = 32'h400;
                    1: r.addr = 32'hFFFF_FFFC;
                    2: r.addr = 32'h8000_0000;
                    default: ;
                endcase
                m1_list.push_back(r);
            end
            step();
        end

        // Drain with a bounded budget
        for (int i = 0; i < 200 && (m0_list.size() + m1_list.size() + owners.size() > 0 || errp); i++)
            step();
        step();
        @(negedge clk_i);
        #6;
        chk("drain_sb0_empty", sb0.size(), 0);
        chk("drain_sb1_empty", sb1.size(), 0);
        chk("drain_reqs_empty", m0_list.size() + m1_list.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
